// File: rtl/simon_game.sv
// Four-switch Simon memory game: the player enters a pattern, the block plays the
// stored sequence back, the player repeats it; a miss or a full memory ends the game.
module simon_game #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       level,
  input  logic [3:0] pattern,
  output logic [3:0] pattern_leds,
  output logic [2:0] mode_leds
);

  typedef enum logic [1:0] {
    INPUT    = 2'd0,
    PLAYBACK = 2'd1,
    REPEAT   = 2'd2,
    DONE     = 2'd3
  } mode_t;

  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

  mode_t             mode_q;
  mode_t             mode_d;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   count_d;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] idx_d;
  logic              hard_q;
  logic              mem_we_s;
  logic              last_s;
  logic [3:0]        mem_rd_s;
  logic [3:0]        mem_q [DEPTH];

  // Easy level accepts only single-switch patterns.
  function automatic logic pattern_valid(input logic hard, input logic [3:0] p);
    logic ok;
    case (p)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: ok = 1'b1;
      default:                            ok = hard;
    endcase
    return ok;
  endfunction

  assign last_s   = ({1'b0, idx_q} == (count_q - CNT_ONE));
  assign mem_rd_s = mem_q[idx_q];

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      mode_q  <= INPUT;
      count_q <= '0;
      idx_q   <= '0;
      hard_q  <= level;
    end else begin
      mode_q  <= mode_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      hard_q  <= hard_q;
    end
  end

  // Sequence storage carries no reset; only entries below count are ever read.
  always_ff @(posedge pclk) begin
    if (mem_we_s) begin
      mem_q[count_q[ADDR_W-1:0]] <= pattern;
    end
  end

  always_comb begin
    mode_d   = mode_q;
    count_d  = count_q;
    idx_d    = idx_q;
    mem_we_s = 1'b0;
    case (mode_q)
      INPUT: begin
        if (pattern_valid(hard_q, pattern)) begin
          mem_we_s = 1'b1;
          count_d  = count_q + CNT_ONE;
          idx_d    = '0;
          mode_d   = PLAYBACK;
        end else begin
          mode_d = INPUT;
        end
      end
      PLAYBACK: begin
        if (last_s) begin
          idx_d  = '0;
          mode_d = REPEAT;
        end else begin
          idx_d = idx_q + IDX_ONE;
        end
      end
      REPEAT: begin
        if (pattern != mem_rd_s) begin
          idx_d  = '0;
          mode_d = DONE;
        end else if (last_s) begin
          idx_d  = '0;
          mode_d = (count_q == CNT_FULL) ? DONE : INPUT;
        end else begin
          idx_d = idx_q + IDX_ONE;
        end
      end
      DONE: begin
        idx_d = last_s ? '0 : (idx_q + IDX_ONE);
      end
      default: begin
        mode_d = INPUT;
        idx_d  = '0;
      end
    endcase
  end

  always_comb begin
    mode_leds    = 3'b001;
    pattern_leds = pattern;
    case (mode_q)
      INPUT:    begin mode_leds = 3'b001; pattern_leds = pattern;  end
      PLAYBACK: begin mode_leds = 3'b010; pattern_leds = mem_rd_s; end
      REPEAT:   begin mode_leds = 3'b100; pattern_leds = pattern;  end
      DONE:     begin mode_leds = 3'b111; pattern_leds = mem_rd_s; end
      default:  begin mode_leds = 3'b001; pattern_leds = pattern;  end
    endcase
  end

endmodule

// File: tb/tb_simon_game.sv
// Directed bench for simon_game: a vector table for the main play flow plus a
// hand-written fill-to-capacity game that must end in DONE.
module tb_simon_game;

  logic       pclk;
  logic       rst;
  logic       level;
  logic [3:0] pattern;
  logic [3:0] pattern_leds;
  logic [2:0] mode_leds;

  int errors = 0;
  int checks = 0;

  simon_game #(.DEPTH(64), .ADDR_W(6)) dut (
    .pclk         (pclk),
    .rst          (rst),
    .level        (level),
    .pattern      (pattern),
    .pattern_leds (pattern_leds),
    .mode_leds    (mode_leds)
  );

  typedef struct {
    logic       rst;
    logic       level;
    logic [3:0] pat;
    logic       adv;
    logic [2:0] exp_mode;
    logic [3:0] exp_leds;
  } vec_t;

  vec_t vecs [28];
  logic [3:0] seq_pats [64];

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic advance();
    pclk = 1'b1;
    #5;
    pclk = 1'b0;
    #4;
  endtask

  task automatic check_outs(input string tag, input logic [2:0] m, input logic [3:0] l);
    #1;
    check({tag, " mode"}, {5'd0, mode_leds}, {5'd0, m});
    check({tag, " leds"}, {4'd0, pattern_leds}, {4'd0, l});
  endtask

  initial begin
    pclk    = 1'b0;
    rst     = 1'b0;
    level   = 1'b0;
    pattern = 4'b0000;
    #5;

    //          rst   lvl   pat      adv   mode    leds
    vecs[0]  = '{1'b1, 1'b0, 4'b0000, 1'b0, 3'b001, 4'b0000};
    vecs[1]  = '{1'b1, 1'b0, 4'b0001, 1'b0, 3'b001, 4'b0001};
    vecs[2]  = '{1'b0, 1'b0, 4'b0001, 1'b0, 3'b001, 4'b0001};
    vecs[3]  = '{1'b0, 1'b0, 4'b0001, 1'b1, 3'b010, 4'b0001};
    vecs[4]  = '{1'b0, 1'b0, 4'b0000, 1'b0, 3'b010, 4'b0001};
    vecs[5]  = '{1'b0, 1'b0, 4'b0000, 1'b1, 3'b100, 4'b0000};
    vecs[6]  = '{1'b0, 1'b0, 4'b0001, 1'b0, 3'b100, 4'b0001};
    vecs[7]  = '{1'b0, 1'b0, 4'b0001, 1'b1, 3'b001, 4'b0001};
    vecs[8]  = '{1'b0, 1'b1, 4'b1010, 1'b1, 3'b001, 4'b1010};
    vecs[9]  = '{1'b0, 1'b1, 4'b1000, 1'b1, 3'b010, 4'b0001};
    vecs[10] = '{1'b0, 1'b1, 4'b1000, 1'b1, 3'b010, 4'b1000};
    vecs[11] = '{1'b0, 1'b1, 4'b1000, 1'b1, 3'b100, 4'b1000};
    vecs[12] = '{1'b0, 1'b1, 4'b0001, 1'b1, 3'b100, 4'b0001};
    vecs[13] = '{1'b0, 1'b1, 4'b0100, 1'b1, 3'b111, 4'b0001};
    vecs[14] = '{1'b0, 1'b1, 4'b0100, 1'b1, 3'b111, 4'b1000};
    vecs[15] = '{1'b0, 1'b1, 4'b0100, 1'b1, 3'b111, 4'b0001};
    vecs[16] = '{1'b0, 1'b1, 4'b0100, 1'b1, 3'b111, 4'b1000};
    vecs[17] = '{1'b1, 1'b1, 4'b0000, 1'b0, 3'b001, 4'b0000};
    vecs[18] = '{1'b0, 1'b1, 4'b1010, 1'b1, 3'b010, 4'b1010};
    vecs[19] = '{1'b0, 1'b1, 4'b1010, 1'b1, 3'b100, 4'b1010};
    vecs[20] = '{1'b0, 1'b1, 4'b1010, 1'b1, 3'b001, 4'b1010};
    vecs[21] = '{1'b0, 1'b0, 4'b1111, 1'b1, 3'b010, 4'b1010};
    vecs[22] = '{1'b1, 1'b0, 4'b0010, 1'b0, 3'b001, 4'b0010};
    vecs[23] = '{1'b0, 1'b0, 4'b0000, 1'b1, 3'b001, 4'b0000};
    vecs[24] = '{1'b0, 1'b0, 4'b0010, 1'b1, 3'b010, 4'b0010};
    vecs[25] = '{1'b0, 1'b0, 4'b0011, 1'b1, 3'b100, 4'b0011};
    vecs[26] = '{1'b0, 1'b0, 4'b0011, 1'b1, 3'b111, 4'b0010};
    vecs[27] = '{1'b0, 1'b0, 4'b0011, 1'b1, 3'b111, 4'b0010};

    for (int v = 0; v < 28; v++) begin
      level   = vecs[v].level;
      pattern = vecs[v].pat;
      rst     = vecs[v].rst;
      #1;
      if (vecs[v].adv) advance();
      check_outs($sformatf("vec[%0d]", v), vecs[v].exp_mode, vecs[v].exp_leds);
    end

    // Fill all 64 entries on the hard level; the final correct repeat wins the game.
    for (int k = 0; k < 64; k++) seq_pats[k] = 4'((k * 7 + 3) % 16);
    level = 1'b1;
    rst   = 1'b1;
    #1;
    check_outs("full reset", 3'b001, pattern);
    rst = 1'b0;
    #1;
    for (int k = 0; k < 64; k++) begin
      pattern = seq_pats[k];
      #1;
      advance();
      for (int i = 0; i <= k; i++) begin
        check_outs($sformatf("full r%0d play%0d", k, i), 3'b010, seq_pats[i]);
        advance();
      end
      for (int i = 0; i <= k; i++) begin
        pattern = seq_pats[i];
        #1;
        advance();
      end
      #1;
      check($sformatf("full r%0d end mode", k), {5'd0, mode_leds},
            (k == 63) ? 8'b0000_0111 : 8'b0000_0001);
    end
    check_outs("full won", 3'b111, seq_pats[0]);
    advance();
    check_outs("full won replay", 3'b111, seq_pats[1]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/simon_game.md
Name: simon_game

Overview:
- Controller and datapath for a four-switch Simon memory game.
- The player adds a pattern to a stored sequence; the block plays the sequence back; the player then repeats it from the switches.
- A wrong guess ends the game, and the block replays the sequence indefinitely.
- Top-level board block: driven by a single pushbutton-derived clock, with switch inputs and LED outputs.

Parameters:
- DEPTH, 64, maximum number of stored patterns (sequence memory entries).
- ADDR_W, 6, index width, equal to log2(DEPTH).

Ports:
- pclk  input  1  game clock; every rising edge is one player "advance" action.
- rst  input  1  reset, asynchronous and active-high; starts a new game.
- level  input  1  difficulty select, sampled only while rst is high.
- pattern  input  4  pattern switches.
- pattern_leds  output  4  pattern display.
- mode_leds  output  3  mode indicator.

Behaviour:
- State:
  - mode ∈ {INPUT, PLAYBACK, REPEAT, DONE}.
  - Sequence memory: DEPTH x 4 bits.
  - count (ADDR_W+1 bits): number of stored patterns.
  - idx (ADDR_W bits): play/guess pointer.
  - hard: latched copy of level.
- mode_leds encoding (combinational from mode): INPUT=3'b001, PLAYBACK=3'b010, REPEAT=3'b100, DONE=3'b111.
- pattern_leds (combinational, no register delay):
  - INPUT and REPEAT: equals pattern.
  - PLAYBACK and DONE: equals mem[idx].
- Reset (rst high, asynchronous):
  - mode=INPUT, count=0, idx=0, hard<=level.
  - Memory contents are don't-care.
  - Outputs during and after reset: mode_leds=001, pattern_leds=pattern.
  - Reset mid-game from any mode returns to this state immediately.
- Validity rule:
  - hard=0: pattern is valid only if exactly one bit is set (0001, 0010, 0100, 1000).
  - hard=1: all 16 values are valid.
  - Changing level after reset has no effect.
- INPUT, on pclk rising edge:
  - Invalid pattern: no state change.
  - Valid pattern: mem[count]<=pattern, count<=count+1, idx<=0, mode<=PLAYBACK.
- PLAYBACK, on pclk rising edge:
  - If idx==count-1: idx<=0, mode<=REPEAT.
  - Otherwise: idx<=idx+1.
  - With count==1, one edge moves to REPEAT.
- REPEAT, on pclk rising edge, compare pattern with mem[idx]:
  - Mismatch: mode<=DONE, idx<=0.
  - Match with idx==count-1: idx<=0; mode<=INPUT, or mode<=DONE if count==DEPTH (memory full, game won).
  - Match otherwise: idx<=idx+1.
- DONE, on pclk rising edge:
  - idx<=(idx==count-1) ? 0 : idx+1, wrapping around the stored sequence.
  - Stays in DONE until reset.
- No other transitions exist. Inputs are sampled only at the pclk edge, with no latency beyond that edge.

Test Plan:
- Reset with level=0 -> mode_leds=001, pattern_leds tracks switches; set pattern=0001 -> pattern_leds=0001.
- In INPUT with pattern=0001, clock -> mode_leds=010; set pattern=0000 -> pattern_leds=0001; clock -> mode_leds=100; pattern=0001 -> pattern_leds=0001; clock (correct guess) -> mode_leds=001.
- Set level=1 mid-game, pattern=1010, clock -> mode stays 001 (invalid, since hard latched 0); pattern=1000, clock -> 010, pattern_leds=0001; clock -> 1000; clock -> mode 100.
- REPEAT with sequence {0001,1000}: guess 0001, clock -> stays 100; guess 0100, clock -> mode_leds=111, pattern_leds=0001; clock -> 1000; clock -> 0001 (wrap), mode still 111.
- Reset with level=1: pattern=1010, clock -> PLAYBACK and pattern_leds=1010; correct repeat -> INPUT.
- Assert rst while in PLAYBACK or DONE -> immediately mode_leds=001, count=0; next valid input stores at index 0.
